// File: rtl/mips_cpu_bus_pkg.sv
// Shared definitions for the MIPS core bus master.
//   state_t              : bus master FSM states
//   ERR_NONE/MISALIGN/TIMEOUT : err_code encodings
//   RESET_VECTOR_DEFAULT : address shown on the idle bus
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_bus_align_chk.sv
// Combinational alignment / byte-enable legality check.
//   addr_lo : byte address bits [1:0]
//   be      : byte enables (fetches are checked as 4'b1111)
//   ok      : 1 when the access is a legal, naturally aligned pattern
// Legal patterns: full word at offset 0, half word at an even offset,
// any single lane. Everything else (including 4'b0000) is rejected.
module mips_cpu_bus_align_chk (
  input  logic [1:0] addr_lo,
  input  logic [3:0] be,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (be)
      4'b1111:                            ok = (addr_lo == 2'b00);
      4'b0011, 4'b1100:                   ok = ~addr_lo[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Avalon-MM master joining the MIPS fetch and data ports onto one bus.
//   clk, rst_n                      : clock, async active-low reset
//   if_req/if_addr/if_rdata/if_done : fetch request port
//   d_req/d_we/d_addr/d_wdata/d_be  : data request port
//   d_rdata/d_done                  : data completion
//   err/err_code                    : sticky first-error report
//   address/read/write/byteenable/writedata/waitrequest/readdata : Avalon
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | bus idle, sample requests (data beats fetch)
// ACCESS | bus cycle in flight, held while waitrequest=1
// DONE   | one-cycle done pulse, requests not sampled
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] RESET_VECTOR   = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Assertion passes straight through; release waits two clock edges.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t      state, state_nxt;
  logic [15:0] wdog, wdog_nxt;
  logic        lat_data, lat_data_nxt;
  logic        lat_we, lat_we_nxt;
  logic [31:0] address_nxt, writedata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic        read_nxt, write_nxt, if_done_nxt, d_done_nxt, err_nxt;
  logic [3:0]  byteenable_nxt;
  logic [1:0]  err_code_nxt;

  // Request selection at latch time: data has fixed priority.
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic        req_write;
  logic        align_ok;

  assign req_addr  = d_req ? d_addr : if_addr;
  assign req_be    = d_req ? d_be : 4'b1111;
  assign req_write = d_req & d_we;

  mips_cpu_bus_align_chk u_align_chk (
    .addr_lo (req_addr[1:0]),
    .be      (req_be),
    .ok      (align_ok)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= IDLE;
      wdog       <= '0;
      lat_data   <= 1'b0;
      lat_we     <= 1'b0;
      address    <= RESET_VECTOR;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      wdog       <= wdog_nxt;
      lat_data   <= lat_data_nxt;
      lat_we     <= lat_we_nxt;
      address    <= address_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      byteenable <= byteenable_nxt;
      writedata  <= writedata_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wdog_nxt       = wdog;
    lat_data_nxt   = lat_data;
    lat_we_nxt     = lat_we;
    address_nxt    = address;
    read_nxt       = read;
    write_nxt      = write;
    byteenable_nxt = byteenable;
    writedata_nxt  = writedata;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_done_nxt    = 1'b0;
    d_done_nxt     = 1'b0;
    err_nxt        = err;
    err_code_nxt   = err_code;

    case (state)
      IDLE: begin
        if (d_req || if_req) begin
          lat_data_nxt = d_req;
          lat_we_nxt   = req_write;
          if (!align_ok) begin
            // Rejected without touching the bus; report straight away.
            state_nxt = DONE;
            if (d_req) begin
              d_done_nxt  = 1'b1;
              d_rdata_nxt = '0;
            end else begin
              if_done_nxt  = 1'b1;
              if_rdata_nxt = '0;
            end
            err_nxt = 1'b1;
            if (err_code == ERR_NONE) err_code_nxt = ERR_MISALIGN;
          end else begin
            state_nxt      = ACCESS;
            address_nxt    = {req_addr[31:2], 2'b00};
            read_nxt       = ~req_write;
            write_nxt      = req_write;
            byteenable_nxt = req_be;
            writedata_nxt  = req_write ? d_wdata : 32'h0;
          end
        end
      end

      ACCESS: begin
        if (waitrequest && (wdog != WD_LAST)) begin
          wdog_nxt = wdog + 16'd1;
        end else begin
          // Either the slave accepted, or the watchdog expired on this
          // last stalled cycle; both release the bus and signal done.
          state_nxt      = DONE;
          read_nxt       = 1'b0;
          write_nxt      = 1'b0;
          byteenable_nxt = '0;
          writedata_nxt  = '0;
          address_nxt    = RESET_VECTOR;
          if (lat_data) begin
            d_done_nxt  = 1'b1;
            d_rdata_nxt = (waitrequest || lat_we) ? 32'h0 : readdata;
          end else begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = waitrequest ? 32'h0 : readdata;
          end
          if (waitrequest) begin
            err_nxt = 1'b1;
            if (err_code == ERR_NONE) err_code_nxt = ERR_TIMEOUT;
          end
        end
      end

      DONE: begin
        wdog_nxt  = '0;
        state_nxt = IDLE;
      end

      default: begin
        wdog_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
module tb_mips_cpu_bus_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata;

  mips_cpu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .err(err), .err_code(err_code),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave model and bus monitor, both acting on the falling edge.
  logic [31:0] slave_rdata = '0;
  int          ws_cfg = 0;
  int          ws_cnt = 0;
  logic        stuck = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, ifd_cnt = 0, dd_cnt = 0;
  int          unstable_cnt = 0;
  logic        prev_active = 1'b0;
  logic [69:0] prev_bus = '0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0;
  logic [3:0]  last_wr_be = '0;

  assign readdata = slave_rdata;

  always @(negedge clk) begin
    if (read) rd_cnt++;
    if (write) begin
      wr_cnt++;
      last_wr_addr = address;
      last_wr_data = writedata;
      last_wr_be   = byteenable;
    end
    if (read && write) both_cnt++;
    if (if_done) ifd_cnt++;
    if (d_done) dd_cnt++;
    if ((read || write) && prev_active &&
        ({address, byteenable, writedata, read, write} != prev_bus))
      unstable_cnt++;
    prev_active = read || write;
    prev_bus    = {address, byteenable, writedata, read, write};
    if ((read || write) && (stuck || ws_cnt < ws_cfg)) begin
      waitrequest = 1'b1;
      ws_cnt++;
    end else begin
      waitrequest = 1'b0;
      ws_cnt = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL reset_read got=%0h exp=0", read); end
    checks++; if (write !== 1'b0) begin failures++; $display("FAIL reset_write got=%0h exp=0", write); end
    checks++; if (address !== 32'hBFC00000) begin failures++; $display("FAIL reset_address got=%h exp=bfc00000", address); end
    checks++; if (byteenable !== 4'h0) begin failures++; $display("FAIL reset_be got=%h exp=0", byteenable); end
    checks++; if (writedata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", writedata); end
    checks++; if ({if_done, d_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {if_done, d_done}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata}); end
    checks++; if ({err, err_code} !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", {err, err_code}); end
  endtask

  task automatic test_fetch();
    int r0;
    r0 = rd_cnt;
    ws_cfg = 0;
    slave_rdata = 32'h3C011234;
    if_addr = 32'hBFC00004;
    if_req = 1'b1;
    step();
    checks++; if ({read, write} !== 2'b10) begin failures++; $display("FAIL fetch_rw got=%b exp=10", {read, write}); end
    checks++; if (address !== 32'hBFC00004) begin failures++; $display("FAIL fetch_addr got=%h exp=bfc00004", address); end
    checks++; if (byteenable !== 4'hF) begin failures++; $display("FAIL fetch_be got=%h exp=f", byteenable); end
    step();
    checks++; if (if_done !== 1'b1 || if_rdata !== 32'h3C011234) begin failures++; $display("FAIL fetch_done got=%b/%h exp=1/3c011234", if_done, if_rdata); end
    checks++; if (read !== 1'b0) begin failures++; $display("FAIL fetch_read_drop got=%b exp=0", read); end
    if_req = 1'b0;
    step();
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_pulse_len got=%b exp=0", if_done); end
    checks++; if (rd_cnt - r0 != 1) begin failures++; $display("FAIL fetch_read_cycles got=%0d exp=1", rd_cnt - r0); end
  endtask

  task automatic test_write_wait();
    int w0, r0, u0, d0, idx;
    w0 = wr_cnt; r0 = rd_cnt; u0 = unstable_cnt; d0 = dd_cnt; idx = -1;
    ws_cfg = 3;
    d_we = 1'b1; d_addr = 32'h00001008; d_be = 4'b0011; d_wdata = 32'h0000ABCD;
    d_req = 1'b1;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      step();
      if (d_done === 1'b1) begin idx = i; d_req = 1'b0; end
    end
    d_req = 1'b0;
    step(); step();
    ws_cfg = 0;
    checks++; if (idx != 4) begin failures++; $display("FAIL write_done_cycle got=%0d exp=4", idx); end
    checks++; if (wr_cnt - w0 != 4) begin failures++; $display("FAIL write_cycles got=%0d exp=4", wr_cnt - w0); end
    checks++; if (rd_cnt - r0 != 0) begin failures++; $display("FAIL write_no_read got=%0d exp=0", rd_cnt - r0); end
    checks++; if (unstable_cnt - u0 != 0) begin failures++; $display("FAIL write_stable got=%0d exp=0", unstable_cnt - u0); end
    checks++; if (dd_cnt - d0 != 1) begin failures++; $display("FAIL write_done_count got=%0d exp=1", dd_cnt - d0); end
    checks++; if ({last_wr_addr, last_wr_be, last_wr_data} !== {32'h00001008, 4'b0011, 32'h0000ABCD}) begin
      failures++; $display("FAIL write_bus got=%h/%h/%h exp=00001008/3/0000abcd", last_wr_addr, last_wr_be, last_wr_data);
    end
  endtask

  task automatic test_priority();
    int di, fi;
    di = -1; fi = -1;
    slave_rdata = 32'h11112222;
    if_addr = 32'hBFC00008;
    d_we = 1'b0; d_addr = 32'h00001000; d_be = 4'b1111;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 30 && (di < 0 || fi < 0); i++) begin
      step();
      if (i == 0) begin
        checks++; if (read !== 1'b1 || address !== 32'h00001000) begin failures++; $display("FAIL prio_first_bus got=%b/%h exp=1/00001000", read, address); end
      end
      if (d_done === 1'b1) begin
        di = i; d_req = 1'b0;
        checks++; if (d_rdata !== 32'h11112222) begin failures++; $display("FAIL prio_d_rdata got=%h exp=11112222", d_rdata); end
      end
      if (if_done === 1'b1) begin
        fi = i; if_req = 1'b0;
        checks++; if (if_rdata !== 32'h11112222) begin failures++; $display("FAIL prio_if_rdata got=%h exp=11112222", if_rdata); end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    checks++; if (di != 1 || fi != 4) begin failures++; $display("FAIL prio_order got=d%0d/if%0d exp=d1/if4", di, fi); end
  endtask

  task automatic test_misalign();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    d_we = 1'b0; d_addr = 32'h00001002; d_be = 4'b1111;
    d_req = 1'b1;
    step();
    checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL misalign_done got=%b/%h exp=1/0", d_done, d_rdata); end
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL misalign_err got=%b/%b exp=1/01", err, err_code); end
    d_req = 1'b0;
    step(); step();
    checks++; if (rd_cnt - r0 != 0 || wr_cnt - w0 != 0) begin failures++; $display("FAIL misalign_nobus got=%0d/%0d exp=0/0", rd_cnt - r0, wr_cnt - w0); end
  endtask

  logic [31:0] va_addr [6] = '{32'h00001003, 32'h00001002, 32'h00001001, 32'h00001000, 32'h00001000, 32'h00001004};
  logic [3:0]  va_be   [6] = '{4'b0100, 4'b1100, 4'b0011, 4'b0000, 4'b0101, 4'b1111};
  int          va_ok   [6] = '{1, 1, 0, 0, 0, 1};

  task automatic test_align_vectors();
    int w0, d0, seen;
    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt; d0 = dd_cnt; seen = 0;
      d_we = 1'b1; d_addr = va_addr[v]; d_be = va_be[v]; d_wdata = 32'h5A5A0000 + v;
      d_req = 1'b1;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        step();
        if (d_done === 1'b1) begin seen = 1; d_req = 1'b0; end
      end
      d_req = 1'b0;
      step();
      checks++; if (wr_cnt - w0 != va_ok[v] || dd_cnt - d0 != 1) begin
        failures++; $display("FAIL align_vec%0d got=wr%0d/done%0d exp=wr%0d/done1", v, wr_cnt - w0, dd_cnt - d0, va_ok[v]);
      end
    end
  endtask

  task automatic test_timeout();
    int r0, idx, seen;
    r0 = rd_cnt; idx = -1;
    stuck = 1'b1;
    slave_rdata = 32'hDEADBEEF;
    if_addr = 32'hBFC00010;
    if_req = 1'b1;
    for (int i = 0; i < 30 && idx < 0; i++) begin
      step();
      if (if_done === 1'b1) begin
        idx = i; if_req = 1'b0;
        checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0", if_rdata); end
      end
    end
    if_req = 1'b0;
    stuck = 1'b0;
    step();
    checks++; if (idx != 4) begin failures++; $display("FAIL timeout_done_cycle got=%0d exp=4", idx); end
    checks++; if (rd_cnt - r0 != TO) begin failures++; $display("FAIL timeout_read_cycles got=%0d exp=%0d", rd_cnt - r0, TO); end
    checks++; if (err !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL timeout_err got=%b/%b exp=1/10", err, err_code); end
    // A clean access afterwards still works and the first error is kept.
    slave_rdata = 32'hCAFEF00D;
    d_we = 1'b0; d_addr = 32'h00000010; d_be = 4'b1111;
    d_req = 1'b1; seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      step();
      if (d_done === 1'b1) begin
        seen = 1; d_req = 1'b0;
        checks++; if (d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL timeout_recover got=%h exp=cafef00d", d_rdata); end
      end
    end
    d_req = 1'b0;
    step();
    checks++; if (seen != 1) begin failures++; $display("FAIL timeout_recover_done got=%0d exp=1", seen); end
    if_addr = 32'hBFC00012;
    if_req = 1'b1;
    step();
    checks++; if (if_done !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL first_error_wins got=%b/%b exp=1/10", if_done, err_code); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int f0;
    f0 = ifd_cnt;
    stuck = 1'b1;
    if_addr = 32'hBFC00020;
    if_req = 1'b1;
    step(); step();
    checks++; if (read !== 1'b1) begin failures++; $display("FAIL rstmid_active got=%b exp=1", read); end
    rst_n = 1'b0;
    #1;
    checks++; if ({read, write} !== 2'b00) begin failures++; $display("FAIL rstmid_async_drop got=%b exp=00", {read, write}); end
    if_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    stuck = 1'b0;
    repeat (4) step();
    checks++; if (ifd_cnt - f0 != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ifd_cnt - f0); end
    checks++; if ({read, write, byteenable} !== 6'b0 || address !== 32'hBFC00000) begin
      failures++; $display("FAIL rstmid_bus got=%b%b/%h/%h exp=00/0/bfc00000", read, write, byteenable, address);
    end
    checks++; if ({err, err_code} !== 3'b000 || d_rdata !== 32'h0 || writedata !== 32'h0) begin
      failures++; $display("FAIL rstmid_regs got=%b%b/%h/%h exp=000/0/0", err, err_code, d_rdata, writedata);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_fetch();
    test_write_wait();
    test_priority();
    test_misalign();
    test_align_vectors();
    do_reset();
    test_timeout();
    test_reset_mid();
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL read_write_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
